coin_sensor_if: RTL and testbench
=================================

# coin_sensor_if

- Upstream front end of the vending controller.
- Converts the two raw, asynchronous, bouncy coin-denomination sensors into clean single-cycle coin codes {i,j} on the clk domain. Each code is the exact input encoding the vending FSM consumes.
- Guarantees at most one coin event per cycle, never emits 11, flags jams, and keeps a saturating accepted-coin count for service diagnostics.

## Interface
- DEB_CYCLES, 4: consecutive synchronized-stable cycles required to accept a coin. Legal range 1..255.
- GAP_CYCLES, 2: consecutive all-clear cycles required before the next coin or before jam release. Legal range 1..255.
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- s1_raw  input  1  Re.1 sensor, asynchronous level
- s2_raw  input  1  Rs.2 sensor, asynchronous level
- i  output  1  coin code MSB; {i,j}=10 means Re.1 accepted (one-cycle pulse)
- j  output  1  coin code LSB; {i,j}=01 means Rs.2 accepted (one-cycle pulse)
- jam  output  1  level; high while both sensors are active or during jam recovery
- coin_cnt  output  8  accepted coins, saturates at 255

## Operation
**Synchronizer**
- 2-flop synchronizer on each raw input.
- p = {s1_sync, s2_sync} is the only value the FSM examines.

**State machine**, 8-bit counter cnt, 2-bit cand register:
- IDLE:
  - p=00: stay.
  - p=10 or 01: cand<=p, cnt<=1. Go to EMIT if DEB_CYCLES==1, else QUAL.
  - p=11: go to JAM, cnt<=0.
- QUAL:
  - p==cand: cnt<=cnt+1. Go to EMIT on the edge where cnt+1==DEB_CYCLES.
  - p=00: go to IDLE; the glitch is dropped with no output.
  - p=11: go to JAM, cnt<=0.
  - p = the other single code: cand<=p, cnt<=1, stay in QUAL (restart).
- EMIT:
  - For exactly one cycle, {i,j}=cand and coin_cnt increments unless already 255.
  - Unconditionally go to WAIT_REL with cnt<=0.
- WAIT_REL:
  - p=00: cnt<=cnt+1. Go to IDLE when cnt+1==GAP_CYCLES.
  - p=10 or 01: cnt<=0 (same coin still present or bouncing; no re-emission).
  - p=11: go to JAM, cnt<=0.
- JAM:
  - jam=1.
  - p=00 counts toward GAP_CYCLES exactly as in WAIT_REL; any nonzero p resets cnt.
  - Exit to IDLE; no coin is emitted for a jammed insertion.

**Outputs**
- {i,j} is 00 in every state except EMIT; 11 is never driven.
- jam is high in the JAM state only.
- i, j, jam, coin_cnt are registered outputs (decoded from next-state into flops), so they change only on clk edges.

## Timing
**Reset**
- rst low: immediately (asynchronously) i=0, j=0, jam=0, coin_cnt=0, state=IDLE, cnt=0, cand=00, sync flops 0.
- Deassertion takes effect at the next clk edge.
- Reset asserted during QUAL or EMIT aborts the coin: no pulse, no count.

**Acceptance latency**
- Raw input stable from before edge 1: sync2 is valid after edge 2, the FSM leaves IDLE at edge 3, and the i/j pulse is high for the cycle following edge DEB_CYCLES+2.
- For the default DEB_CYCLES=4, the pulse follows edge 6.

**Spacing**
- Minimum spacing between pulses: DEB_CYCLES + GAP_CYCLES + 1 cycles.
- The downstream FSM never sees back-to-back codes.

**Width and boundary rules**
- cnt compare uses full 8-bit width.
- DEB_CYCLES=1 and GAP_CYCLES=1 are legal and skip QUAL or complete recovery in one all-clear cycle.
- coin_cnt holds at 255; the EMIT pulse is still issued.
- Simultaneous sensor activation (p=11) in any state except EMIT goes to JAM on that edge. In EMIT the pulse completes first, then WAIT_REL detects the 11.

## Test plan
- Reset and idle: rst=0 then 1, sensors 00 for 20 cycles -> i=j=jam=0, coin_cnt=0 throughout.
- Clean Re.1: s1_raw high for 10 cycles, defaults -> {i,j}=10 for exactly one cycle after edge 6, coin_cnt=1, no further pulse until s1_raw is low for 2 synced cycles.
- Bounce rejection: s2_raw toggling 1,0,1,1,0 then high for 8 cycles -> exactly one {i,j}=01 pulse, 4 stable cycles after the final rise reaches sync2; coin_cnt increments by 1.
- Jam: s1_raw and s2_raw both high for 5 cycles, then both low -> jam=1 from edge 3 until 2 all-clear synced cycles, no i/j pulse, coin_cnt unchanged.
- Sequence into controller: Re.1, Rs.2, Rs.2, each with a gap -> pulses 10, 01, 01 in order, each isolated by at least 7 cycles; coin_cnt=3.
- Reset mid-QUAL and saturation: rst low at edge 4 of a coin -> no pulse; then preload 255 coins -> 256th coin pulses and coin_cnt stays 255.

Source files
------------

// File: rtl/coin_sensor_if.sv
// coin_sensor_if: front end of the vending controller.
// Turns the two raw, asynchronous, bouncy coin sensors into clean
// single-cycle coin codes {i,j} (10 = Re.1, 01 = Rs.2). It emits at most
// one code per cycle, never drives 11, flags jams, and keeps a saturating
// count of accepted coins for service diagnostics.
//
// DEB_CYCLES: consecutive stable synchronized cycles needed to accept a coin (1..255).
// GAP_CYCLES: consecutive all-clear cycles needed before the next coin or
//             before a jam is released (1..255).
//
// All outputs are registered. They are decoded from the next state, so a
// code appears on the same edge on which the FSM enters EMIT.

module coin_sensor_if #(
    parameter int DEB_CYCLES = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s1_raw,
    input  logic       s2_raw,
    output logic       i,
    output logic       j,
    output logic       jam,
    output logic [7:0] coin_cnt
);

    // Thresholds are compared against the full 8-bit counter.
    localparam logic [7:0] DEB_LIM = 8'(DEB_CYCLES);
    localparam logic [7:0] GAP_LIM = 8'(GAP_CYCLES);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        QUAL     = 3'd1,
        EMIT     = 3'd2,
        WAIT_REL = 3'd3,
        JAM      = 3'd4
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [7:0] cnt;
    logic [7:0] next_cnt;
    logic [7:0] cnt_inc;
    logic [1:0] cand;
    logic [1:0] next_cand;

    logic       s1_meta;
    logic       s1_sync;
    logic       s2_meta;
    logic       s2_sync;
    logic [1:0] p;

    // Two-flop synchronizer on each raw sensor level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_meta <= 1'b0;
            s1_sync <= 1'b0;
            s2_meta <= 1'b0;
            s2_sync <= 1'b0;
        end else begin
            s1_meta <= s1_raw;
            s1_sync <= s1_meta;
            s2_meta <= s2_raw;
            s2_sync <= s2_meta;
        end
    end

    // The FSM looks only at the synchronized pair.
    assign p       = {s1_sync, s2_sync};
    assign cnt_inc = cnt + 8'd1;

    // State, counter and candidate-code registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 8'd0;
            cand  <= 2'b00;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            cand  <= next_cand;
        end
    end

    // Next-state logic: debounce, emit once, wait for release, jam recovery.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        next_cand  = cand;
        case (state)
            IDLE: begin
                case (p)
                    2'b00: begin
                        next_state = IDLE;
                    end
                    2'b11: begin
                        next_state = JAM;
                        next_cnt   = 8'd0;
                    end
                    default: begin
                        next_cand  = p;
                        next_cnt   = 8'd1;
                        next_state = (DEB_LIM == 8'd1) ? EMIT : QUAL;
                    end
                endcase
            end
            QUAL: begin
                case (p)
                    2'b00: begin
                        // Glitch shorter than the debounce window: drop it.
                        next_state = IDLE;
                        next_cnt   = 8'd0;
                    end
                    2'b11: begin
                        next_state = JAM;
                        next_cnt   = 8'd0;
                    end
                    default: begin
                        if (p == cand) begin
                            next_cnt = cnt_inc;
                            if (cnt_inc == DEB_LIM) begin
                                next_state = EMIT;
                            end
                        end else begin
                            // The other denomination took over: restart on it.
                            next_cand = p;
                            next_cnt  = 8'd1;
                        end
                    end
                endcase
            end
            EMIT: begin
                // One-cycle pulse; a simultaneous 11 is caught in WAIT_REL.
                next_state = WAIT_REL;
                next_cnt   = 8'd0;
            end
            WAIT_REL: begin
                case (p)
                    2'b00: begin
                        next_cnt = cnt_inc;
                        if (cnt_inc == GAP_LIM) begin
                            next_state = IDLE;
                            next_cnt   = 8'd0;
                        end
                    end
                    2'b11: begin
                        next_state = JAM;
                        next_cnt   = 8'd0;
                    end
                    default: begin
                        // Same coin still present or bouncing: no re-emission.
                        next_cnt = 8'd0;
                    end
                endcase
            end
            JAM: begin
                if (p == 2'b00) begin
                    next_cnt = cnt_inc;
                    if (cnt_inc == GAP_LIM) begin
                        next_state = IDLE;
                        next_cnt   = 8'd0;
                    end
                end else begin
                    next_cnt = 8'd0;
                end
            end
            default: begin
                next_state = IDLE;
                next_cnt   = 8'd0;
                next_cand  = 2'b00;
            end
        endcase
    end

    // Registered outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i        <= 1'b0;
            j        <= 1'b0;
            jam      <= 1'b0;
            coin_cnt <= 8'd0;
        end else begin
            i   <= (next_state == EMIT) && (next_cand == 2'b10);
            j   <= (next_state == EMIT) && (next_cand == 2'b01);
            jam <= (next_state == JAM);
            if ((next_state == EMIT) && (coin_cnt != 8'hFF)) begin
                coin_cnt <= coin_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_coin_sensor_if.sv
// tb_coin_sensor_if: directed bench for coin_sensor_if with default
// parameters. A vector table covers idle, clean insertion, bounce and jam
// cycle by cycle. Hand-written sequences then cover a multi-coin stream,
// reset during qualification, and counter saturation. During those
// sequences a pulse monitor checks each pulse against an expected queue.

module tb_coin_sensor_if;

    logic       clk;
    logic       rst;
    logic       s1_raw;
    logic       s2_raw;
    logic       i;
    logic       j;
    logic       jam;
    logic [7:0] coin_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    coin_sensor_if #(.DEB_CYCLES(4), .GAP_CYCLES(2)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .s1_raw   (s1_raw),
        .s2_raw   (s2_raw),
        .i        (i),
        .j        (j),
        .jam      (jam),
        .coin_cnt (coin_cnt)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One vector per clock: inputs driven before an edge, outputs expected after it.
    typedef struct {
        logic       s1;
        logic       s2;
        logic       ei;
        logic       ej;
        logic       ejam;
        logic [7:0] ecnt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic s1, input logic s2, input logic ei,
                                input logic ej, input logic ejam,
                                input logic [7:0] ecnt, input int n);
        vec_t v;
        v.s1 = s1; v.s2 = s2; v.ei = ei; v.ej = ej; v.ejam = ejam; v.ecnt = ecnt;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold a raw sensor code for hi cycles, then all-clear for lo cycles.
    task automatic insert(input logic [1:0] code, input int hi, input int lo);
        {s1_raw, s2_raw} = code;
        repeat (hi) tick();
        {s1_raw, s2_raw} = 2'b00;
        repeat (lo) tick();
    endtask

    // Scoreboard: expected pulse codes, checked as each pulse appears.
    logic [1:0] exp_q[$];
    logic       mon_en = 1'b0;
    int         cyc = 0;
    int         last_pulse = -1000;
    int         pulse_seen = 0;

    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (mon_en && (i || j)) begin
            pulse_seen++;
            check("pulse_spacing_ok", pulse_seen, 8'((cyc - last_pulse) >= 7), 8'd1);
            last_pulse = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", pulse_seen, {6'd0, i, j}, 8'd0);
            end else begin
                check("pulse_code", pulse_seen, {6'd0, i, j}, {6'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        int         pulses_before;
        logic [1:0] code;

        // Scenario A: 20 idle cycles after reset.
        add(0, 0, 0, 0, 0, 8'd0, 20);
        // Scenario B: Re.1 held for 10 cycles; pulse after edge 6, release done at edge 14.
        add(1, 0, 0, 0, 0, 8'd0, 5);
        add(1, 0, 1, 0, 0, 8'd1, 1);
        add(1, 0, 0, 0, 0, 8'd1, 4);
        add(0, 0, 0, 0, 0, 8'd1, 6);
        // Scenario C: Rs.2 bounces 1,0,1,1,0 and is then high for 8 cycles.
        add(0, 1, 0, 0, 0, 8'd1, 1);
        add(0, 0, 0, 0, 0, 8'd1, 1);
        add(0, 1, 0, 0, 0, 8'd1, 2);
        add(0, 0, 0, 0, 0, 8'd1, 1);
        add(0, 1, 0, 0, 0, 8'd1, 5);
        add(0, 1, 0, 1, 0, 8'd2, 1);
        add(0, 1, 0, 0, 0, 8'd2, 2);
        add(0, 0, 0, 0, 0, 8'd2, 5);
        // Scenario D: both sensors high for 5 cycles; jam from edge 3 through edge 8.
        add(1, 1, 0, 0, 0, 8'd2, 2);
        add(1, 1, 0, 0, 1, 8'd2, 3);
        add(0, 0, 0, 0, 1, 8'd2, 3);
        add(0, 0, 0, 0, 0, 8'd2, 2);

        rst    = 1'b0;
        s1_raw = 1'b0;
        s2_raw = 1'b0;
        repeat (3) tick();
        check("rst_i", 0, {7'd0, i}, 8'd0);
        check("rst_j", 0, {7'd0, j}, 8'd0);
        check("rst_jam", 0, {7'd0, jam}, 8'd0);
        check("rst_coin_cnt", 0, coin_cnt, 8'd0);
        rst = 1'b1;

        for (int k = 0; k < vecs.size(); k++) begin
            s1_raw = vecs[k].s1;
            s2_raw = vecs[k].s2;
            tick();
            check("vec_i", k, {7'd0, i}, {7'd0, vecs[k].ei});
            check("vec_j", k, {7'd0, j}, {7'd0, vecs[k].ej});
            check("vec_jam", k, {7'd0, jam}, {7'd0, vecs[k].ejam});
            check("vec_coin_cnt", k, coin_cnt, vecs[k].ecnt);
        end

        // Sequence into controller: Re.1, Rs.2, Rs.2.
        mon_en = 1'b1;
        exp_q.push_back(2'b10); insert(2'b10, 6, 5);
        exp_q.push_back(2'b01); insert(2'b01, 6, 5);
        exp_q.push_back(2'b01); insert(2'b01, 6, 5);
        repeat (4) tick();
        check("seq_queue_drained", 0, 8'(exp_q.size()), 8'd0);
        check("seq_coin_cnt", 0, coin_cnt, 8'd5);

        // Reset asserted during qualification aborts the coin.
        pulses_before = pulse_seen;
        s1_raw = 1'b1;
        repeat (4) tick();
        rst = 1'b0;
        #1;
        check("midqual_rst_coin_cnt", 0, coin_cnt, 8'd0);
        check("midqual_rst_i", 0, {7'd0, i}, 8'd0);
        s1_raw = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        repeat (10) tick();
        check("midqual_no_pulse", 0, 8'(pulse_seen - pulses_before), 8'd0);
        check("midqual_coin_cnt", 1, coin_cnt, 8'd0);

        // Saturation: 255 coins, then a 256th that still pulses.
        for (int k = 0; k < 255; k++) begin
            code = (k % 2 == 0) ? 2'b10 : 2'b01;
            exp_q.push_back(code);
            insert(code, 6, 5);
        end
        check("sat_coin_cnt_255", 0, coin_cnt, 8'd255);
        pulses_before = pulse_seen;
        exp_q.push_back(2'b10);
        insert(2'b10, 6, 5);
        check("sat_pulse_issued", 0, 8'(pulse_seen - pulses_before), 8'd1);
        check("sat_coin_cnt_hold", 0, coin_cnt, 8'd255);
        check("sat_queue_drained", 0, 8'(exp_q.size()), 8'd0);
        check("sat_jam_low", 0, {7'd0, jam}, 8'd0);
        mon_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
